// File: rtl/decoder_acc_pkg.sv
// ---------------------------------------------------------------------------
// decoder_acc_pkg
// Shared definitions for the decoder accumulate/requantise slice.
//   - default widths for product, accumulator and output paths
//   - default requantisation right-shift
//   - FSM state enum used by decoder_acc_requant
//   - OUT_MAX / OUT_MIN clip limits for the default output width
// Optional feature macro used elsewhere in the slice: DECODER_ACC_RELU_EN
// ---------------------------------------------------------------------------
package decoder_acc_pkg;

    localparam int PROD_WIDTH_DEF = 25;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF  = 16;
    localparam int SHIFT_DEF      = 8;

    localparam int OUT_MAX = (2 ** (OUT_WIDTH_DEF - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_WIDTH_DEF - 1));

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_acc_requant_if.sv
// ---------------------------------------------------------------------------
// decoder_acc_requant_if
// Groups the product input stream, the bias and the result output stream.
//   prod_din/prod_valid/prod_last/prod_ready : signed product beats in
//   bias                                     : signed bias (used at finish)
//   dout/dout_valid/dout_ready/sat_flag      : requantised result out
// Modports:
//   master : the upstream/downstream environment driving the block
//   slave  : the decoder_acc_requant block itself
// ---------------------------------------------------------------------------
interface decoder_acc_requant_if
    import decoder_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
);

    logic [PROD_WIDTH-1:0] prod_din;
    logic                  prod_valid;
    logic                  prod_last;
    logic                  prod_ready;
    logic [OUT_WIDTH-1:0]  bias;
    logic [OUT_WIDTH-1:0]  dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  sat_flag;

    modport master (
        output prod_din, prod_valid, prod_last, bias, dout_ready,
        input  prod_ready, dout, dout_valid, sat_flag
    );

    modport slave (
        input  prod_din, prod_valid, prod_last, bias, dout_ready,
        output prod_ready, dout, dout_valid, sat_flag
    );

endinterface

// File: rtl/decoder_acc_sat.sv
// ---------------------------------------------------------------------------
// decoder_acc_sat
// Combinational finishing stage: adds the bias scaled into accumulator units,
// rounds half-up while shifting right, clips to the signed output range and
// optionally applies ReLU.
// Ports:
//   acc_i  : accumulated sum (ACC_WIDTH, two's complement)
//   bias_i : signed bias (OUT_WIDTH)
//   res_o  : requantised, clipped result (OUT_WIDTH)
//   sat_o  : 1 when the rounded value had to be clipped
// Optional feature: DECODER_ACC_RELU_EN forces negative results to 0.
// ---------------------------------------------------------------------------
module decoder_acc_sat
    import decoder_acc_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [OUT_WIDTH-1:0] bias_i,
    output logic [OUT_WIDTH-1:0] res_o,
    output logic                 sat_o
);

    // Everything is evaluated one bit wider than the accumulator so the bias
    // add and rounding constant cannot overflow for in-range accumulators.
    localparam logic signed [ACC_WIDTH:0] ROUND_HALF = (ACC_WIDTH + 1)'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] CLIP_HI =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] CLIP_LO = ~CLIP_HI;

    logic signed [ACC_WIDTH:0] accExt;
    logic signed [ACC_WIDTH:0] biasExt;
    logic signed [ACC_WIDTH:0] sumVal;
    logic signed [ACC_WIDTH:0] biasedVal;
    logic signed [ACC_WIDTH:0] shiftedVal;
    logic [OUT_WIDTH-1:0]      clippedVal;

    // Bias is moved into accumulator scale before rounding, so the rounding
    // applies to the combined value; the shift is arithmetic (floor), which
    // together with the +half constant gives round-half-up.
    always_comb begin
        accExt     = {acc_i[ACC_WIDTH-1], acc_i};
        biasExt    = {{(ACC_WIDTH + 1 - OUT_WIDTH){bias_i[OUT_WIDTH-1]}}, bias_i};
        sumVal     = accExt + (biasExt <<< SHIFT);
        biasedVal  = sumVal + ROUND_HALF;
        shiftedVal = biasedVal >>> SHIFT;
    end

    // Clip to the signed output range; sat_o reflects clipping only and is
    // not influenced by the optional ReLU stage below.
    always_comb begin
        clippedVal = shiftedVal[OUT_WIDTH-1:0];
        sat_o      = 1'b0;
        if (shiftedVal > CLIP_HI) begin
            clippedVal = CLIP_HI[OUT_WIDTH-1:0];
            sat_o      = 1'b1;
        end else if (shiftedVal < CLIP_LO) begin
            clippedVal = CLIP_LO[OUT_WIDTH-1:0];
            sat_o      = 1'b1;
        end
    end

    // Optional ReLU on the already clipped value.
    always_comb begin
`ifdef DECODER_ACC_RELU_EN
        res_o = clippedVal[OUT_WIDTH-1] ? '0 : clippedVal;
`else
        res_o = clippedVal;
`endif
    end

endmodule

// File: rtl/decoder_acc_requant.sv
// ---------------------------------------------------------------------------
// decoder_acc_requant
// Accumulates a vector of signed products, then adds a bias, requantises by
// a rounding right-shift and clips to the output width.
// Ports:
//   ap_clk : single clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : decoder_acc_requant_if.slave
//            product stream in (prod_din/valid/last/ready), bias,
//            result stream out (dout/dout_valid/dout_ready/sat_flag)
// Optional feature: DECODER_ACC_RELU_EN (ReLU on the result, see
// decoder_acc_sat).
// ---------------------------------------------------------------------------
module decoder_acc_requant
    import decoder_acc_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int SHIFT      = SHIFT_DEF
) (
    input logic                  ap_clk,
    input logic                  ap_rst,
    decoder_acc_requant_if.slave bus
);

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  firstBeat_q, firstBeat_d;
    logic [OUT_WIDTH-1:0]  dout_q, dout_d;
    logic                  doutValid_q, doutValid_d;
    logic                  sat_q, sat_d;

    logic                  prodReady;
    logic                  beatAccepted;
    logic [ACC_WIDTH-1:0]  prodExt;
    logic [OUT_WIDTH-1:0]  satRes;
    logic                  satFlag;

    decoder_acc_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat (
        .acc_i  (acc_q),
        .bias_i (bus.bias),
        .res_o  (satRes),
        .sat_o  (satFlag)
    );

    // Ready is withheld during reset as well, so a beat presented while reset
    // is asserted can never be counted.
    always_comb begin
        prodReady    = (state_q == S_ACC) && !ap_rst;
        beatAccepted = bus.prod_valid && prodReady;
        prodExt      = {{(ACC_WIDTH - PROD_WIDTH){bus.prod_din[PROD_WIDTH-1]}}, bus.prod_din};
    end

    // Next-state logic. The result register is loaded on leaving S_FIN and
    // dout_valid is raised one cycle later, so data is already settled when
    // valid appears. Leaving S_OUT only on the registered handshake keeps
    // prod_ready from depending combinationally on dout_ready.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        firstBeat_d = firstBeat_q;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        sat_d       = sat_q;

        unique case (state_q)
            S_ACC: begin
                if (beatAccepted) begin
                    acc_d       = firstBeat_q ? prodExt : acc_q + prodExt;
                    firstBeat_d = bus.prod_last;
                    if (bus.prod_last) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                dout_d  = satRes;
                sat_d   = satFlag;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (!doutValid_q) begin
                    doutValid_d = 1'b1;
                end else if (bus.dout_ready) begin
                    doutValid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial sum or pending
    // result so nothing from an interrupted vector is ever emitted.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            firstBeat_q <= 1'b1;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            firstBeat_q <= firstBeat_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.prod_ready = prodReady;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = doutValid_q;
    assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_decoder_acc_requant.sv
// ---------------------------------------------------------------------------
// tb_decoder_acc_requant
// Directed bench for decoder_acc_requant with SHIFT=8 and default widths.
// Honours DECODER_ACC_RELU_EN when choosing expected values.
// ---------------------------------------------------------------------------
module tb_decoder_acc_requant;
    import decoder_acc_pkg::*;

    logic ap_clk;
    logic ap_rst;
    int   totalChecks;
    int   badChecks;

    decoder_acc_requant_if #(.PROD_WIDTH(25), .OUT_WIDTH(16)) bus ();

    decoder_acc_requant #(
        .PROD_WIDTH (25),
        .ACC_WIDTH  (32),
        .OUT_WIDTH  (16),
        .SHIFT      (8)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    // Free-running clock.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one beat (called at a negedge) and holds it until accepted;
    // returns at the negedge after the accepting edge with valid dropped.
    task automatic applyStimulus(input logic [24:0] value, input logic last);
        int waited;
        bus.prod_din   = value;
        bus.prod_valid = 1'b1;
        bus.prod_last  = last;
        waited = 0;
        while (!bus.prod_ready && waited < 50) begin
            @(negedge ap_clk);
            waited++;
        end
        if (!bus.prod_ready) begin
            checkOutput("beat_accept", 32'd0, 32'd1);
        end else begin
            @(posedge ap_clk);
            @(negedge ap_clk);
        end
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
    endtask

    // Waits (bounded) for the result after the last beat, checks latency,
    // value and flag, optionally stalls the output, then completes the
    // handshake and checks the block is ready again right away.
    task automatic getResult(input string tag, input logic [15:0] expDout,
                             input logic expSat, input int stall);
        int lat;
        logic [15:0] heldDout;
        logic        heldSat;
        lat = 0;
        while (!bus.dout_valid && lat < 20) begin
            @(negedge ap_clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
        checkOutput({tag, "_dout"}, {16'd0, bus.dout}, {16'd0, expDout});
        checkOutput({tag, "_sat"}, {31'd0, bus.sat_flag}, {31'd0, expSat});
        heldDout = bus.dout;
        heldSat  = bus.sat_flag;
        for (int i = 0; i < stall; i++) begin
            bus.prod_din   = 25'sd5000;
            bus.prod_valid = 1'b1;
            bus.prod_last  = 1'b1;
            @(negedge ap_clk);
            checkOutput({tag, "_stall_dout"}, {16'd0, bus.dout}, {16'd0, heldDout});
            checkOutput({tag, "_stall_sat"}, {31'd0, bus.sat_flag}, {31'd0, heldSat});
            checkOutput({tag, "_stall_valid"}, {31'd0, bus.dout_valid}, 32'd1);
            checkOutput({tag, "_stall_ready"}, {31'd0, bus.prod_ready}, 32'd0);
        end
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.dout_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'd0, bus.dout_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, bus.prod_ready}, 32'd1);
    endtask

    // Directed sequence of vectors with hand-computed results.
    initial begin
        logic [15:0] expNeg;
        logic [15:0] expNegSat;
        totalChecks = 0;
        badChecks   = 0;
        ap_rst         = 1'b1;
        bus.prod_din   = '0;
        bus.prod_valid = 1'b0;
        bus.prod_last  = 1'b0;
        bus.bias       = '0;
        bus.dout_ready = 1'b0;

`ifdef DECODER_ACC_RELU_EN
        expNeg    = 16'h0000;
        expNegSat = 16'h0000;
`else
        expNeg    = 16'hFFFC;
        expNegSat = 16'(OUT_MIN);
`endif

        // Reset state.
        @(negedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_prod_ready", {31'd0, bus.prod_ready}, 32'd0);
        ap_rst = 1'b0;
        #1;
        checkOutput("rst_dout", {16'd0, bus.dout}, 32'd0);
        checkOutput("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        checkOutput("rst_sat", {31'd0, bus.sat_flag}, 32'd0);
        checkOutput("rst_ready_after", {31'd0, bus.prod_ready}, 32'd1);
        @(negedge ap_clk);

        // 256+512+768 = 1536 -> (1536+128)>>8 = 6.
        applyStimulus(25'sd256, 1'b0);
        applyStimulus(25'sd512, 1'b0);
        applyStimulus(25'sd768, 1'b1);
        getResult("three_beats", 16'd6, 1'b0, 0);

        // Rounding boundary: 384 -> 2, 383 -> 1.
        applyStimulus(25'sd384, 1'b1);
        getResult("round_up", 16'd2, 1'b0, 0);
        applyStimulus(25'sd383, 1'b1);
        getResult("round_down", 16'd1, 1'b0, 0);

        // Bias only: (0 + 256 + 128) >> 8 = 1.
        bus.bias = 16'sd1;
        applyStimulus(25'sd0, 1'b1);
        getResult("bias_only", 16'd1, 1'b0, 0);

        // Negative bias: (1000 - 512 + 128) >> 8 = 2.
        bus.bias = -16'sd2;
        applyStimulus(25'sd1000, 1'b1);
        getResult("bias_neg", 16'd2, 1'b0, 0);
        bus.bias = '0;

        // Positive saturation: 16777214 -> 65536 -> clip 32767.
        applyStimulus(25'sd8388607, 1'b0);
        applyStimulus(25'sd8388607, 1'b1);
        getResult("sat_pos", 16'(OUT_MAX), 1'b1, 0);

        // Negative: (-1024+128)>>>8 = -4, ReLU gives 0.
        applyStimulus(-25'sd1024, 1'b1);
        getResult("neg_small", expNeg, 1'b0, 0);

        // Negative saturation: -16777216 -> -65536 -> clip -32768.
        applyStimulus(-25'sd8388608, 1'b0);
        applyStimulus(-25'sd8388608, 1'b1);
        getResult("sat_neg", expNegSat, 1'b1, 0);

        // Output stall for 5 cycles, then the next vector right after the
        // handshake: 256 -> 1, then 384 -> 2.
        applyStimulus(25'sd256, 1'b1);
        getResult("stall", 16'd1, 1'b0, 5);
        applyStimulus(25'sd384, 1'b1);
        getResult("after_stall", 16'd2, 1'b0, 0);

        // Reset mid-vector discards the partial sum.
        applyStimulus(25'sd1000, 1'b0);
        applyStimulus(25'sd2000, 1'b0);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (3) @(negedge ap_clk);
        checkOutput("midrst_no_result", {31'd0, bus.dout_valid}, 32'd0);
        applyStimulus(25'sd256, 1'b1);
        getResult("midrst", 16'd1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
